// File: rtl/mysystem_pio_in.sv
// Avalon-MM input PIO slave: synchronised WIDTH-bit input bus, per-bit edge
// capture with write-one-to-clear, and a maskable level- or edge-driven irq.
module mysystem_pio_in #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned IRQ_MODE    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_d;
    logic [2:0]       warm_cnt;
    logic             warm_done;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign data_in      = sync_q[SYNC_STAGES-1];
    assign warm_done    = (warm_cnt == WARM_LAST);
    assign wr_en        = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            data_d   <= '0;
            warm_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            data_d <= data_in;
            if (!warm_done) begin
                warm_cnt <= warm_cnt + 3'd1;
            end
        end
    end

    // Edges are ignored until the synchroniser and data_d hold post-reset samples.
    always_comb begin
        rise = data_in & ~data_d;
        fall = ~data_in & data_d;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
        if (!warm_done) begin
            edge_det = '0;
        end
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && address == 2'd3) begin
            clr_bits = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // A fresh edge outranks a clear landing on the same bit.
            edgecapture <= (edgecapture & ~clr_bits) | edge_det;
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux = 32'(data_in);
            2'd2:    read_mux = 32'(irqmask);
            2'd3:    read_mux = 32'(edgecapture);
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

    always_comb begin
        if (IRQ_MODE == 0) begin
            irq = |(data_in & irqmask);
        end else begin
            irq = |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_mysystem_pio_in.sv
// Bench for mysystem_pio_in: three configurations share one bus and input pins,
// checked each cycle against a sample-history model plus literal expectations.
module tb_mysystem_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = 8'h00;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // A: rising, edge irq, 2 stages.  B: any edge, edge irq, 3 stages.
    // C: falling, level irq, 2 stages.
    mysystem_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_MODE(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a));
    mysystem_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MODE(1), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b));
    mysystem_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_MODE(0), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_port), .irq(irq_c));

    int p_edge [3] = '{0, 2, 1};
    int p_mode [3] = '{1, 1, 0};
    int p_sync [3] = '{2, 3, 2};

    // Model: pin values seen at each clock edge since reset release.
    logic [7:0]  samp [$];
    logic [7:0]  m_mask [3];
    logic [7:0]  m_ec [3];
    logic [31:0] m_rd [3];
    logic        m_irq [3];
    int          k, s;
    logic [7:0]  din_pre, dd_pre, din_post, det, clr;

    function automatic logic [7:0] hist(input int j);
        if (j >= 1 && j <= samp.size()) return samp[j-1];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                samp.delete();
                for (int i = 0; i < 3; i++) begin
                    m_mask[i] = '0; m_ec[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
                end
            end else begin
                samp.push_back(in_port);
                k = samp.size();
                for (int i = 0; i < 3; i++) begin
                    s        = p_sync[i];
                    din_pre  = hist(k - s);
                    dd_pre   = hist(k - s - 1);
                    din_post = hist(k - s + 1);
                    case (p_edge[i])
                        0:       det = din_pre & ~dd_pre;
                        1:       det = ~din_pre & dd_pre;
                        default: det = din_pre ^ dd_pre;
                    endcase
                    if (k < s + 2) det = 8'h00;
                    case (address)
                        2'd0:    m_rd[i] = {24'h0, din_pre};
                        2'd2:    m_rd[i] = {24'h0, m_mask[i]};
                        2'd3:    m_rd[i] = {24'h0, m_ec[i]};
                        default: m_rd[i] = 32'h0;
                    endcase
                    clr = 8'h00;
                    if (chipselect && !write_n) begin
                        if (address == 2'd2) m_mask[i] = writedata[7:0];
                        if (address == 2'd3) clr = writedata[7:0];
                    end
                    m_ec[i] = (m_ec[i] & ~clr) | det;
                    m_irq[i] = (p_mode[i] != 0) ? |(m_ec[i] & m_mask[i]) : |(din_post & m_mask[i]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_rd_a", rd_a, m_rd[0]);
            chk("model_irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
            chk("model_rd_b", rd_b, m_rd[1]);
            chk("model_irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
            chk("model_rd_c", rd_c, m_rd[2]);
            chk("model_irq_c", {31'h0, irq_c}, {31'h0, m_irq[2]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        in_port = 8'hFF;
        repeat (3) tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("warm_data_early", rd_a, 32'h0);
        tick();
        chk("warm_data", rd_a, 32'hFF);
        address = 2'd3;
        repeat (4) tick();
        chk("warm_ec_a", rd_a, 32'h0);
        chk("warm_ec_b", rd_b, 32'h0);
        chk("warm_irq_a", {31'h0, irq_a}, 32'h0);

        in_port = 8'h00;
        repeat (6) tick();
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        address = 2'd3;
        in_port = 8'h01;
        tick(); tick();
        chk("irq_e2", {31'h0, irq_a}, 32'h0);
        tick();
        chk("irq_e3", {31'h0, irq_a}, 32'h1);
        tick();
        chk("ec_read", rd_a, 32'h01);
        wr(2'd3, 32'h01);
        chk("irq_clr", {31'h0, irq_a}, 32'h0);

        in_port = 8'h00;
        repeat (5) tick();
        wr(2'd3, 32'hFF);
        in_port = 8'h01;
        tick(); tick();
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h01;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        tick();
        chk("set_wins", rd_a, 32'h01);
        chk("set_wins_irq", {31'h0, irq_a}, 32'h1);

        wr(2'd2, 32'h00);
        wr(2'd3, 32'hFF);
        address = 2'd3;
        in_port = 8'h09;
        repeat (5) tick();
        chk("any_rise", rd_b, 32'h08);
        chk("any_rise_irq", {31'h0, irq_b}, 32'h0);
        wr(2'd3, 32'h08);
        in_port = 8'h01;
        tick();
        chk("any_clr", rd_b, 32'h00);
        repeat (4) tick();
        chk("any_fall", rd_b, 32'h08);
        chk("any_fall_irq", {31'h0, irq_b}, 32'h0);

        wr(2'd2, 32'h80);
        in_port = 8'h81;
        tick();
        chk("lvl_e1", {31'h0, irq_c}, 32'h0);
        tick();
        chk("lvl_e2", {31'h0, irq_c}, 32'h1);
        address = 2'd1;
        tick();
        chk("rsvd", rd_c, 32'h0);
        wr(2'd0, 32'hFF);
        address = 2'd2;
        tick();
        chk("wr0_ignored", rd_c, 32'h80);
        in_port = 8'h01;
        tick(); tick();
        chk("lvl_fall", {31'h0, irq_c}, 32'h0);

        wr(2'd2, 32'hFF);
        wr(2'd3, 32'hFF);
        in_port = 8'h5B;
        address = 2'd3;
        repeat (5) tick();
        chk("ec_5a", rd_a, 32'h5A);
        chk("ec_5a_irq", {31'h0, irq_a}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_rd_a", rd_a, 32'h0);
        chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
        chk("rst_rd_b", rd_b, 32'h0);
        chk("rst_irq_c", {31'h0, irq_c}, 32'h0);
        tick();
        reset_n = 1'b1;
        address = 2'd2;
        tick(); tick();
        chk("rst_mask", rd_a, 32'h0);
        address = 2'd3;
        repeat (6) tick();
        chk("rst_ec_a", rd_a, 32'h0);
        chk("rst_ec_b", rd_b, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
